// File: rtl/axi_timer_slave.sv
// AXI4-lite timer slave: 32-bit down-counter with a prescaler, auto-reload
// and a sticky expiry flag that drives irq when the interrupt is enabled.
// Word-addressed register map (address already shifted down by 2):
//   0 CTRL {ie, reload, en}   1 LOAD   2 COUNT   3 STATUS {exp} W1C
//   4 PRESC                   5-7 reserved (read 0, writes dropped)
module axi_timer_slave #(
   parameter int                 sword     = 32,
   parameter int                 PRESC_W   = 16,
   parameter logic [PRESC_W-1:0] PRESC_RST = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             axi_awvalid,
   output logic             axi_awready,
   input  logic [sword-1:0] axi_awaddr,
   input  logic [2:0]       axi_awprot,
   input  logic             axi_wvalid,
   output logic             axi_wready,
   input  logic [sword-1:0] axi_wdata,
   input  logic [3:0]       axi_wstrb,
   output logic             axi_bvalid,
   input  logic             axi_bready,
   input  logic             axi_arvalid,
   output logic             axi_arready,
   input  logic [sword-1:0] axi_araddr,
   input  logic [2:0]       axi_arprot,
   output logic             axi_rvalid,
   input  logic             axi_rready,
   output logic [sword-1:0] axi_rdata,
   output logic             irq
);

   typedef enum logic {W_IDLE, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   localparam logic [2:0] A_CTRL   = 3'd0;
   localparam logic [2:0] A_LOAD   = 3'd1;
   localparam logic [2:0] A_COUNT  = 3'd2;
   localparam logic [2:0] A_STATUS = 3'd3;
   localparam logic [2:0] A_PRESC  = 3'd4;

   wstate_t            w_state_q, w_state_d;
   rstate_t            r_state_q, r_state_d;
   logic [2:0]         ctrl_q, ctrl_d;        // {ie, reload, en}
   logic [sword-1:0]   load_q, load_d;
   logic [sword-1:0]   count_q, count_d;
   logic               exp_q, exp_d;
   logic [PRESC_W-1:0] presc_q, presc_d;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d;
   logic [sword-1:0]   rdata_q, rdata_d;

   logic             wr_fire, rd_fire, tick, expire;
   logic [2:0]       wr_sel;
   logic [sword-1:0] rd_mux;

   // Only the low three address bits are decoded; prot is ignored.
   logic unused_ok;
   assign unused_ok = ^{axi_awprot, axi_arprot, axi_awaddr[sword-1:3], axi_araddr[sword-1:3]};

   // Byte-lane merge of write data into an existing register value.
   function automatic logic [sword-1:0] wmerge(input logic [sword-1:0] old_v,
                                               input logic [sword-1:0] new_v,
                                               input logic [3:0]       strb);
      logic [sword-1:0] res;
      res = old_v;
      for (int b = 0; b < 4; b++)
         if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
      return res;
   endfunction

   // A write is accepted only when address and data arrive together.
   assign wr_fire = (w_state_q == W_IDLE) & axi_awvalid & axi_wvalid & ~RST;
   assign rd_fire = (r_state_q == R_IDLE) & axi_arvalid & ~RST;
   assign wr_sel  = axi_awaddr[2:0];

   assign tick   = ctrl_q[0] & (pcnt_q == presc_q);
   assign expire = tick & (count_q == '0);

   // Write channel FSM: ready pulses on acceptance, response held until bready.
   always_comb begin
      w_state_d   = w_state_q;
      axi_awready = 1'b0;
      axi_wready  = 1'b0;
      axi_bvalid  = 1'b0;
      case (w_state_q)
         W_IDLE: begin
            if (wr_fire) begin
               axi_awready = 1'b1;
               axi_wready  = 1'b1;
               w_state_d   = W_RESP;
            end
         end
         W_RESP: begin
            axi_bvalid = 1'b1;
            if (axi_bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read address decode; the value is captured on the arready edge.
   always_comb begin
      rd_mux = '0;
      case (axi_araddr[2:0])
         A_CTRL:   rd_mux = sword'(ctrl_q);
         A_LOAD:   rd_mux = load_q;
         A_COUNT:  rd_mux = count_q;
         A_STATUS: rd_mux = sword'(exp_q);
         A_PRESC:  rd_mux = sword'(presc_q);
         default:  rd_mux = '0;
      endcase
   end

   // Read channel FSM: data registered at acceptance, held until rready.
   always_comb begin
      r_state_d   = r_state_q;
      rdata_d     = rdata_q;
      axi_arready = 1'b0;
      axi_rvalid  = 1'b0;
      case (r_state_q)
         R_IDLE: begin
            if (rd_fire) begin
               axi_arready = 1'b1;
               rdata_d     = rd_mux;
               r_state_d   = R_DATA;
            end
         end
         R_DATA: begin
            axi_rvalid = 1'b1;
            if (axi_rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   // Timer next state; bus writes are applied after the timer so they win,
   // except that a new expiry beats a simultaneous clear of exp.
   always_comb begin
      ctrl_d  = ctrl_q;
      load_d  = load_q;
      count_d = count_q;
      exp_d   = exp_q;
      presc_d = presc_q;
      pcnt_d  = '0;

      if (ctrl_q[0] && !tick) pcnt_d = pcnt_q + PRESC_W'(1);

      if (tick) begin
         if (count_q != '0) begin
            count_d = count_q - sword'(1);
         end else begin
            exp_d = 1'b1;
            if (ctrl_q[1]) count_d   = load_q;
            else           ctrl_d[0] = 1'b0;
         end
      end

      if (wr_fire) begin
         case (wr_sel)
            A_CTRL:   if (axi_wstrb[0]) ctrl_d = axi_wdata[2:0];
            A_LOAD:   load_d  = wmerge(load_q, axi_wdata, axi_wstrb);
            A_COUNT:  count_d = wmerge(count_q, axi_wdata, axi_wstrb);
            A_STATUS: if (axi_wstrb[0] && axi_wdata[0]) exp_d = expire;
            A_PRESC:  presc_d = PRESC_W'(wmerge(sword'(presc_q), axi_wdata, axi_wstrb));
            default:  ;
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         w_state_q <= W_IDLE;
         r_state_q <= R_IDLE;
         ctrl_q    <= '0;
         load_q    <= '0;
         count_q   <= '0;
         exp_q     <= 1'b0;
         presc_q   <= PRESC_RST;
         pcnt_q    <= '0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         r_state_q <= r_state_d;
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         count_q   <= count_d;
         exp_q     <= exp_d;
         presc_q   <= presc_d;
         pcnt_q    <= pcnt_d;
         rdata_q   <= rdata_d;
      end
   end

   assign axi_rdata = rdata_q;
   assign irq       = exp_q & ctrl_q[2];

endmodule

// File: tb/tb_axi_timer_slave.sv
// Bench for axi_timer_slave: directed bus sequences, a cycle-level reference
// model of the register/timer behaviour checked every cycle, and literal
// expectations at the key points of each scenario.
module tb_axi_timer_slave;

   localparam logic [15:0] PRST = 16'd3;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
   logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0, irq;
   logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
   logic [3:0]  wstrb = '0;

   int tests = 0;
   int fails = 0;

   always #5 CLK = ~CLK;

   axi_timer_slave #(.sword(32), .PRESC_W(16), .PRESC_RST(PRST)) dut (
      .CLK(CLK), .RST(RST),
      .axi_awvalid(awvalid), .axi_awready(awready), .axi_awaddr(awaddr), .axi_awprot(3'b000),
      .axi_wvalid(wvalid), .axi_wready(wready), .axi_wdata(wdata), .axi_wstrb(wstrb),
      .axi_bvalid(bvalid), .axi_bready(bready),
      .axi_arvalid(arvalid), .axi_arready(arready), .axi_araddr(araddr), .axi_arprot(3'b000),
      .axi_rvalid(rvalid), .axi_rready(rready), .axi_rdata(rdata),
      .irq(irq)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [2:0]  m_ctrl;
   logic [31:0] m_load, m_count;
   logic        m_exp;
   logic [15:0] m_presc;
   int          m_phase;
   logic        m_widle, m_ridle;
   logic [31:0] rdq[$];

   function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = n[b*8 +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_rd(input logic [2:0] a);
      case (a)
         3'd0:    return {29'd0, m_ctrl};
         3'd1:    return m_load;
         3'd2:    return m_count;
         3'd3:    return {31'd0, m_exp};
         3'd4:    return {16'd0, m_presc};
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_reset();
      m_ctrl = '0; m_load = '0; m_count = '0; m_exp = 1'b0;
      m_presc = PRST; m_phase = 0; m_widle = 1'b1; m_ridle = 1'b1;
      rdq.delete();
   endtask

   task automatic model_step();
      logic        wf, rf, tk, ex;
      logic [2:0]  n_ctrl;
      logic [31:0] n_load, n_count, t32;
      logic        n_exp;
      logic [15:0] n_presc;
      int          n_phase;
      if (RST) begin
         model_reset();
         return;
      end
      wf = m_widle && awvalid && wvalid;
      rf = m_ridle && arvalid;
      if (rf) rdq.push_back(m_rd(araddr[2:0]));
      // timer: one tick per (PRESC+1) enabled clocks
      tk = m_ctrl[0] && (m_phase == int'(m_presc));
      ex = tk && (m_count == 0);
      n_phase = (m_ctrl[0] && !tk) ? m_phase + 1 : 0;
      n_ctrl = m_ctrl; n_load = m_load; n_count = m_count; n_exp = m_exp; n_presc = m_presc;
      if (tk && !ex) n_count = m_count - 1;
      if (ex) begin
         n_exp = 1'b1;
         if (m_ctrl[1]) n_count = m_load;
         else n_ctrl[0] = 1'b0;
      end
      if (wf) begin
         case (awaddr[2:0])
            3'd0: if (wstrb[0]) n_ctrl = wdata[2:0];
            3'd1: n_load = bmerge(m_load, wdata, wstrb);
            3'd2: n_count = bmerge(m_count, wdata, wstrb);
            3'd3: if (wstrb[0] && wdata[0]) n_exp = ex;
            3'd4: begin t32 = bmerge({16'd0, m_presc}, wdata, wstrb); n_presc = t32[15:0]; end
            default: ;
         endcase
      end
      if (!m_widle && bready) m_widle = 1'b1;
      else if (wf) m_widle = 1'b0;
      if (!m_ridle && rready) begin m_ridle = 1'b1; rdq.delete(0); end
      else if (rf) m_ridle = 1'b0;
      m_ctrl = n_ctrl; m_load = n_load; m_count = n_count; m_exp = n_exp;
      m_presc = n_presc; m_phase = n_phase;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge CLK);
         model_step();
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge CLK);
         chk("m_irq", irq, m_exp & m_ctrl[2]);
         chk("m_bvalid", bvalid, !m_widle);
         chk("m_rvalid", rvalid, !m_ridle);
         chk("m_awready", awready, m_widle && awvalid && wvalid && !RST);
         chk("m_wready", wready, m_widle && awvalid && wvalid && !RST);
         chk("m_arready", arready, m_ridle && arvalid && !RST);
         if (!m_ridle && rdq.size() > 0) chk("m_rdata", rdata, rdq[0]);
      end
   end

   // ---------------- bus tasks ----------------
   // Returns 1ns after the accepting edge.
   task automatic wr(input logic [2:0] a, input logic [31:0] dat, input logic [3:0] s);
      int n;
      @(posedge CLK); #1;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = {29'd0, a}; wdata = dat; wstrb = s;
      n = 0;
      @(negedge CLK);
      while (!awready && n < 20) begin @(negedge CLK); n++; end
      chk("aw_accept", awready, 1);
      @(posedge CLK); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   // Read with rready held low for three rvalid cycles; checks data stability.
   task automatic rd(input logic [2:0] a, output logic [31:0] d);
      int n;
      @(posedge CLK); #1;
      arvalid = 1'b1; araddr = {29'd0, a}; rready = 1'b0;
      n = 0;
      @(negedge CLK);
      while (!arready && n < 20) begin @(negedge CLK); n++; end
      chk("ar_accept", arready, 1);
      @(posedge CLK); #1;
      arvalid = 1'b0;
      @(negedge CLK);
      d = rdata;
      chk("r_valid", rvalid, 1);
      repeat (2) begin
         @(negedge CLK);
         chk("r_hold", rvalid, 1);
         chk("r_stable", rdata, d);
      end
      @(posedge CLK); #1;
      rready = 1'b1;
      @(negedge CLK);
      chk("r_stable", rdata, d);
      @(posedge CLK); #1;
      rready = 1'b0;
   endtask

   // Safety net so the run always ends.
   initial begin
      #400000;
      fails++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // ---------------- directed scenarios ----------------
   initial begin
      logic [31:0] d;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0; bready = 1'b1;
      @(negedge CLK);
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_irq", irq, 0);

      // reset values of every address
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         chk("rst_reg", d, (a == 4) ? 32'd3 : 32'd0);
      end

      // auto-reload period of 5 clocks with interrupt
      wr(3'd4, 32'd0, 4'hF);
      wr(3'd1, 32'd4, 4'hF);
      wr(3'd2, 32'd4, 4'hF);
      wr(3'd0, 32'd7, 4'hF);
      for (int i = 1; i <= 5; i++) begin
         @(posedge CLK); @(negedge CLK);
         chk("irq_rise5", irq, (i == 5) ? 32'd1 : 32'd0);
      end
      wr(3'd3, 32'd1, 4'hF);            // accepted 7 clocks after CTRL write
      @(negedge CLK);
      chk("w1c_irq", irq, 0);
      for (int i = 8; i <= 10; i++) begin
         @(posedge CLK); @(negedge CLK);
         chk("irq_period", irq, (i == 10) ? 32'd1 : 32'd0);
      end
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd3, 32'd1, 4'hF);

      // one-shot with prescaler 2: expiry 6 clocks after enable
      wr(3'd4, 32'd2, 4'hF);
      wr(3'd2, 32'd1, 4'hF);
      wr(3'd0, 32'd1, 4'hF);
      repeat (4) @(posedge CLK);
      rd(3'd3, d);                       // sampled on the 6th edge: not yet set
      chk("exp_before6", d, 0);
      rd(3'd3, d);
      chk("exp_after6", d, 1);
      rd(3'd0, d);
      chk("en_selfclear", d, 0);
      rd(3'd2, d);
      chk("count_stays0", d, 0);
      chk("irq_ie0", irq, 0);

      // byte strobes on COUNT, then a COUNT write on a tick edge
      wr(3'd2, 32'hFFFF_FFFF, 4'b0011);
      rd(3'd2, d);
      chk("count_strb", d, 32'h0000_FFFF);
      wr(3'd4, 32'd0, 4'hF);
      wr(3'd0, 32'd1, 4'hF);
      wr(3'd2, 32'd100, 4'hF);
      rd(3'd2, d);                       // one tick after the write
      chk("count_wr_wins", d, 32'd99);
      wr(3'd0, 32'd0, 4'hF);
      wr(3'd3, 32'd1, 4'hF);

      // address leads data by 4 cycles; response held until bready
      @(posedge CLK); #1;
      bready = 1'b0;
      awvalid = 1'b1; awaddr = 32'd1; wdata = 32'hA5A5_1234; wstrb = 4'hF; wvalid = 1'b0;
      repeat (4) begin
         @(negedge CLK);
         chk("aw_wait_awready", awready, 0);
         chk("aw_wait_wready", wready, 0);
      end
      @(posedge CLK); #1;
      wvalid = 1'b1;
      @(negedge CLK);
      chk("both_awready", awready, 1);
      chk("both_wready", wready, 1);
      @(posedge CLK);
      repeat (3) begin
         @(negedge CLK);
         chk("ready_once", awready, 0);
         chk("bvalid_hold", bvalid, 1);
         @(posedge CLK);
      end
      #1 awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
      @(negedge CLK);
      chk("bvalid_hold", bvalid, 1);
      @(posedge CLK); @(negedge CLK);
      chk("bvalid_done", bvalid, 0);
      rd(3'd1, d);
      chk("load_rb", d, 32'hA5A5_1234);

      // reset while both responses are pending
      wr(3'd2, 32'd50, 4'hF);
      wr(3'd0, 32'd7, 4'hF);
      @(posedge CLK); #1;
      bready = 1'b0; rready = 1'b0;
      awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'd4; wdata = 32'd9; wstrb = 4'hF;
      arvalid = 1'b1; araddr = 32'd1;
      @(negedge CLK);
      chk("cc_awready", awready, 1);
      chk("cc_arready", arready, 1);
      @(posedge CLK); #1;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge CLK);
      chk("pre_rst_bvalid", bvalid, 1);
      chk("pre_rst_rvalid", rvalid, 1);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); @(negedge CLK);
      chk("rst_mid_bvalid", bvalid, 0);
      chk("rst_mid_rvalid", rvalid, 0);
      chk("rst_mid_irq", irq, 0);
      @(posedge CLK); #1;
      RST = 1'b0; bready = 1'b1;
      repeat (3) begin
         @(negedge CLK);
         chk("no_resp_after_rst", bvalid, 0);
      end
      for (int a = 0; a < 8; a++) begin
         rd(3'(a), d);
         chk("rst2_reg", d, (a == 4) ? 32'd3 : 32'd0);
      end

      repeat (2) @(posedge CLK);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
